// File: rtl/apb_spi_pkg.sv
// apb_spi_pkg: register map constants and shared types for the APB SPI
// peripherals (receiver now, transmitter later).
//   REG_*      byte offsets within the peripheral window
//   CTRL_*     bit positions in the CTRL/STAT register
//   LEVEL_LSB  low bit of the FIFO level field in CTRL/STAT
//   DATA_VALID position of the valid flag in a DATA read
package apb_spi_pkg;

  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_DATA = 8'h04;

  localparam int unsigned CTRL_MSB    = 0;
  localparam int unsigned CTRL_NEMPTY = 1;
  localparam int unsigned CTRL_FULL   = 2;
  localparam int unsigned CTRL_OVF    = 3;
  localparam int unsigned CTRL_FLUSH  = 4;
  localparam int unsigned CTRL_IRQEN  = 5;
  localparam int unsigned LEVEL_LSB   = 8;
  localparam int unsigned DATA_VALID  = 8;

  // APB slave phase: idle, or one wait state completed and responding
  typedef enum logic {
    APB_IDLE,
    APB_RESP
  } apb_phase_e;

endpackage

// File: rtl/apb_spi_slave_rx_if.sv
// apb_spi_slave_rx_if: APB bus signals for the SPI receive peripheral.
//   psel/penable/pwrite/paddr/pwdata : master -> slave
//   prdata/pready                    : slave  -> master
interface apb_spi_slave_rx_if;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: synchronous FIFO for received SPI bytes.
//   clk, rst_i (async active-low)
//   push_i/data_i : write; ignored when full unless a pop happens the same cycle
//   pop_i         : read; ignored when empty
//   flush_i       : empty the FIFO; overrides a simultaneous push
//   data_o        : head entry (meaningful only when not empty)
//   full_o, empty_o, level_o (clog2(FIFO_DEPTH)+1 bits)
module spi_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                            clk,
  input  logic                            rst_i,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic                            flush_i,
  input  logic [WIDTH-1:0]                data_i,
  output logic [WIDTH-1:0]                data_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(FIFO_DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(FIFO_DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/apb_spi_slave_rx.sv
// apb_spi_slave_rx: SPI mode-3 receive-only slave with an APB register view.
// SPI inputs are synchronised and oversampled in the clk domain; completed
// bytes go into spi_rx_fifo, read via DATA (0x04), status/control at CTRL (0x00).
//   clk, rst_i (async active-low)
//   apb                          : APB slave (one wait state, pready for one cycle)
//   spi_sck, spi_mosi, spi_cs_n  : asynchronous SPI pins
//   irq                          : only when SPI_RX_IRQ_EN is defined
module apb_spi_slave_rx
  import apb_spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_i,
  apb_spi_slave_rx_if.slave  apb,
  input  logic               spi_sck,
  input  logic               spi_mosi,
  input  logic               spi_cs_n
`ifdef SPI_RX_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  apb_phase_e             state_q;
  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sck_prev_q;
  logic [2:0]             cnt_q;
  logic [7:0]             shreg_q, shift_d;
  logic                   msb_q, ovf_q;
  logic                   sck_s, mosi_s, cs_s, sck_rise;
  logic                   push, pop, flush, drop, ovf_clr;
  logic                   acc_fire, wr_ctrl, rd_data;
  logic [7:0]             head;
  logic                   full, empty;
  logic [LW-1:0]          level;
  logic [31:0]            ctrl_rd, data_rd, prdata_d;
  logic                   unused_pwdata;
`ifdef SPI_RX_IRQ_EN
  logic                   irq_en_q, irq_q;
`endif

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
  assign shift_d  = msb_q ? {shreg_q[6:0], mosi_s} : {mosi_s, shreg_q[7:1]};
  assign push     = sck_rise & (cnt_q == 3'd7);

  // Side effects happen in the pready cycle; psel low there aborts the access
  assign acc_fire = (state_q == APB_RESP) & apb.psel;
  assign wr_ctrl  = acc_fire & apb.pwrite & (apb.paddr == REG_CTRL);
  assign rd_data  = acc_fire & ~apb.pwrite & (apb.paddr == REG_DATA);
  assign flush    = wr_ctrl & apb.pwdata[CTRL_FLUSH];
  assign ovf_clr  = wr_ctrl & apb.pwdata[CTRL_OVF];
  assign pop      = rd_data & ~empty;
  assign drop     = push & full & ~pop & ~flush;

  assign unused_pwdata = ^{apb.pwdata[31:5], apb.pwdata[2:1]};

  spi_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (shift_d),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_MSB]    = msb_q;
    ctrl_rd[CTRL_NEMPTY] = ~empty;
    ctrl_rd[CTRL_FULL]   = full;
    ctrl_rd[CTRL_OVF]    = ovf_q;
`ifdef SPI_RX_IRQ_EN
    ctrl_rd[CTRL_IRQEN]  = irq_en_q;
`endif
    ctrl_rd[LEVEL_LSB +: LW] = level;

    data_rd = '0;
    if (!empty) begin
      data_rd[7:0]        = head;
      data_rd[DATA_VALID] = 1'b1;
    end

    prdata_d = '0;
    if (acc_fire && !apb.pwrite) begin
      if (apb.paddr == REG_CTRL)      prdata_d = ctrl_rd;
      else if (apb.paddr == REG_DATA) prdata_d = data_rd;
    end
  end

  assign apb.pready = acc_fire;
  assign apb.prdata = prdata_d;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= APB_IDLE;
      sck_sync_q  <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b1;
      cnt_q       <= '0;
      shreg_q     <= '0;
      msb_q       <= 1'b1;
      ovf_q       <= 1'b0;
`ifdef SPI_RX_IRQ_EN
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;

      case (state_q)
        APB_IDLE: if (apb.psel && apb.penable) state_q <= APB_RESP;
        default:  state_q <= APB_IDLE;
      endcase

      if (cs_s) begin
        cnt_q <= '0;
      end else if (sck_rise) begin
        cnt_q   <= cnt_q + 3'd1;
        shreg_q <= shift_d;
      end

      if (wr_ctrl) msb_q <= apb.pwdata[CTRL_MSB];

      // Set after clear so a simultaneous drop keeps overflow asserted
      if (ovf_clr) ovf_q <= 1'b0;
      if (drop)    ovf_q <= 1'b1;

`ifdef SPI_RX_IRQ_EN
      if (wr_ctrl) irq_en_q <= apb.pwdata[CTRL_IRQEN];
      irq_q <= irq_en_q & (~empty | ovf_q);
`endif
    end
  end

`ifdef SPI_RX_IRQ_EN
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_apb_spi_slave_rx.sv
// tb_apb_spi_slave_rx: self-checking bench for apb_spi_slave_rx.
// A byte-queue reference model tracks expected FIFO contents, overflow and
// msb_first; randomized frames and register accesses are checked against it.
// Define SPI_RX_IRQ_EN to also exercise the interrupt output.
module tb_apb_spi_slave_rx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SYNC  = 2;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic sck = 1'b1;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
`ifdef SPI_RX_IRQ_EN
  logic irq;
`endif

  apb_spi_slave_rx_if bus();

  apb_spi_slave_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .apb      (bus.slave),
    .spi_sck  (sck),
    .spi_mosi (mosi),
    .spi_cs_n (cs_n)
`ifdef SPI_RX_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_q[$];
  bit m_msb = 1'b1;
  bit m_ovf = 1'b0;
  bit m_irqen = 1'b0;

  // Wire order is always b[7] first; the receiver's bit order decides the value
  function automatic logic [7:0] m_rx(input logic [7:0] b);
    logic [7:0] r;
    if (m_msb) return b;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic void m_push(input logic [7:0] v);
    if (m_q.size() < DEPTH) m_q.push_back(v);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] m_ctrl();
    logic [31:0] r;
    r = '0;
    r[0] = m_msb;
    r[1] = (m_q.size() != 0);
    r[2] = (m_q.size() == DEPTH);
    r[3] = m_ovf;
    r[5] = m_irqen;
    r = r | (32'(m_q.size()) << 8);
    return r;
  endfunction

  function automatic void m_write_ctrl(input logic [31:0] wd);
    m_msb = wd[0];
    if (wd[3]) m_ovf = 1'b0;
    if (wd[4]) m_q.delete();
`ifdef SPI_RX_IRQ_EN
    m_irqen = wd[5];
`endif
  endfunction

  function automatic logic [31:0] m_read_data();
    if (m_q.size() == 0) return 32'h0;
    return 32'h100 | 32'(m_q.pop_front());
  endfunction

  // One APB access; ok reports pready low in the access cycle, high for
  // exactly the following cycle, and low again afterwards.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output bit ok);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
    @(negedge clk);
    bus.penable = 1'b1;
    #1 ok = (bus.pready === 1'b0) && (bus.prdata === 32'h0);
    @(negedge clk);
    ok = ok && (bus.pready === 1'b1);
    rd = bus.prdata;
    @(negedge clk);
    ok = ok && (bus.pready === 1'b0) && (bus.prdata === 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int unsigned nbits);
    for (int i = 0; i < int'(nbits); i++) begin
      @(negedge clk); sck = 1'b0; mosi = b[7-i];
      repeat (3) @(negedge clk);
      @(negedge clk); sck = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic spi_frame(input logic [7:0] bytes[$]);
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    foreach (bytes[i]) begin
      spi_bits(bytes[i], 8);
      m_push(m_rx(bytes[i]));
    end
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  // Sends byte b, timing the final SCK rise so the receiver's push lands on
  // the same clock edge as the side effect of the given APB access.
  task automatic spi_byte_with_apb(input logic [7:0] b, input logic wr, input logic [7:0] addr,
                                   input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(b, 7);
    @(negedge clk); sck = 1'b0; mosi = b[0];
    repeat (3) @(negedge clk);
    @(negedge clk); sck = 1'b1;
    repeat (SYNC - 2) @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
    @(negedge clk); bus.penable = 1'b1;
    @(negedge clk); rd = bus.prdata;
    @(negedge clk); bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd; bit ok;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.pready !== 1'b0 || bus.prdata !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: pready=%b prdata=%h, want 0/0", bus.pready, bus.prdata);
    end
`ifdef SPI_RX_IRQ_EN
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL reset_ctrl: got %h want 00000001", rd); end
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL reset_ctrl_timing: got %b want 1", ok); end
    apb(1'b0, 8'h04, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000000", rd); end
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL reset_data_timing: got %b want 1", ok); end
  endtask

  task automatic test_msb_first();
    logic [31:0] rd, exp; bit ok;
    spi_frame('{8'hA5});
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== 32'h103) begin n_err++; $display("FAIL msb_ctrl: got %h want 00000103", rd); end
    apb(1'b0, 8'h04, 32'h0, rd, ok);
    exp = m_read_data();
    n_cmp++;
    if (rd !== 32'h1A5 || exp !== 32'h1A5) begin
      n_err++; $display("FAIL msb_data: got %h want 000001a5", rd);
    end
    apb(1'b0, 8'h04, 32'h0, rd, ok);
    exp = m_read_data();
    n_cmp++;
    if (rd !== exp || ok !== 1'b1) begin n_err++; $display("FAIL msb_empty_read: got %h want %h", rd, exp); end
  endtask

  task automatic test_lsb_first();
    logic [31:0] rd, exp; bit ok;
    apb(1'b1, 8'h00, 32'h0, rd, ok);
    m_write_ctrl(32'h0);
    spi_frame('{8'h80});
    apb(1'b0, 8'h04, 32'h0, rd, ok);
    exp = m_read_data();
    n_cmp++;
    if (rd !== 32'h101 || exp !== 32'h101) begin
      n_err++; $display("FAIL lsb_data: got %h want 00000101", rd);
    end
    apb(1'b1, 8'h00, 32'h1, rd, ok);
    m_write_ctrl(32'h1);
  endtask

  task automatic test_abort();
    logic [31:0] rd, exp; bit ok;
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(8'hFF, 5);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    spi_frame('{8'h3C});
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== m_ctrl() || rd[12:8] !== 5'd1) begin
      n_err++; $display("FAIL abort_level: got %h want %h", rd, m_ctrl());
    end
    apb(1'b0, 8'h04, 32'h0, rd, ok);
    exp = m_read_data();
    n_cmp++;
    if (rd !== 32'h13C || exp !== 32'h13C) begin
      n_err++; $display("FAIL abort_data: got %h want 0000013c", rd);
    end
  endtask

  task automatic test_apb_abort();
    logic [31:0] rd; bit ok;
    spi_frame('{8'h5A});
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h04;
    @(negedge clk); bus.penable = 1'b1;
    @(negedge clk); bus.psel = 1'b0; bus.penable = 1'b0;
    #1;
    n_cmp++;
    if (bus.pready !== 1'b0) begin n_err++; $display("FAIL apb_abort_pready: got %b want 0", bus.pready); end
    repeat (2) @(negedge clk);
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== m_ctrl()) begin n_err++; $display("FAIL apb_abort_nopop: got %h want %h", rd, m_ctrl()); end
  endtask

  task automatic test_misc_regs();
    logic [31:0] rd; bit ok;
    apb(1'b0, 8'h08, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== 32'h0 || ok !== 1'b1) begin
      n_err++; $display("FAIL other_offset: got %h ok=%b want 00000000 ok=1", rd, ok);
    end
    apb(1'b1, 8'h04, 32'hFFFF_FFFF, rd, ok);
    apb(1'b1, 8'h0C, 32'hFFFF_FFFF, rd, ok);
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== m_ctrl()) begin n_err++; $display("FAIL ignored_writes: got %h want %h", rd, m_ctrl()); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, exp; bit ok;
    logic [7:0] bytes[$];
    apb(1'b1, 8'h00, 32'h19, rd, ok);
    m_write_ctrl(32'h19);
    for (int i = 0; i <= int'(DEPTH); i++) bytes.push_back(8'(i));
    spi_frame(bytes);
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== m_ctrl() || rd[3:2] !== 2'b11) begin
      n_err++; $display("FAIL ovf_ctrl: got %h want %h", rd, m_ctrl());
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      apb(1'b0, 8'h04, 32'h0, rd, ok);
      exp = m_read_data();
      n_cmp++;
      if (rd !== exp || rd !== (32'h100 | 32'(i))) begin
        n_err++; $display("FAIL ovf_data%0d: got %h want %h", i, rd, exp);
      end
    end
    apb(1'b1, 8'h00, 32'h9, rd, ok);
    m_write_ctrl(32'h9);
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== 32'h1 || m_ctrl() !== 32'h1) begin
      n_err++; $display("FAIL ovf_w1c: got %h want 00000001", rd);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd, exp; bit ok;
    logic [7:0] bytes[$];
    logic [7:0] b;
    for (int i = 0; i < int'(DEPTH); i++) bytes.push_back(8'($urandom));
    spi_frame(bytes);
    b = 8'($urandom);
    spi_byte_with_apb(b, 1'b0, 8'h04, 32'h0, rd);
    exp = m_read_data();
    m_push(m_rx(b));
    n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL sim_pop_data: got %h want %h", rd, exp); end
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== m_ctrl() || rd !== 32'h807) begin
      n_err++; $display("FAIL sim_pop_push_level: got %h want %h", rd, m_ctrl());
    end
    apb(1'b0, 8'h04, 32'h0, rd, ok);
    exp = m_read_data();
    n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL sim_head_after: got %h want %h", rd, exp); end
    spi_byte_with_apb(8'($urandom), 1'b1, 8'h00, 32'h11, rd);
    m_write_ctrl(32'h11);
    apb(1'b0, 8'h00, 32'h0, rd, ok);
    n_cmp++;
    if (rd !== m_ctrl() || rd !== 32'h1) begin
      n_err++; $display("FAIL sim_flush_push: got %h want 00000001", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, wd; bit ok;
    logic [7:0] bytes[$];
    for (int step = 0; step < 24; step++) begin
      case ($urandom_range(0, 3))
        0: begin
          bytes.delete();
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) bytes.push_back(8'($urandom));
          spi_frame(bytes);
        end
        1: begin
          apb(1'b0, 8'h04, 32'h0, rd, ok);
          exp = m_read_data();
          n_cmp++;
          if (rd !== exp || ok !== 1'b1) begin
            n_err++; $display("FAIL rand_data step%0d: got %h want %h", step, rd, exp);
          end
        end
        2: begin
          wd = 32'($urandom) & 32'hFFFF_FFCF;
          if ($urandom_range(0, 5) == 0) wd[4] = 1'b1;
          apb(1'b1, 8'h00, wd, rd, ok);
          m_write_ctrl(wd);
        end
        default: begin
          apb(1'b0, 8'h00, 32'h0, rd, ok);
          n_cmp++;
          if (rd !== m_ctrl()) begin
            n_err++; $display("FAIL rand_ctrl step%0d: got %h want %h", step, rd, m_ctrl());
          end
        end
      endcase
    end
  endtask

`ifdef SPI_RX_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd, exp; bit ok;
    apb(1'b1, 8'h00, 32'h39, rd, ok);
    m_write_ctrl(32'h39);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle: got %b want 0", irq); end
    spi_frame('{8'h77});
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_assert: got %b want 1", irq); end
    apb(1'b0, 8'h04, 32'h0, rd, ok);
    exp = m_read_data();
    n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL irq_data: got %h want %h", rd, exp); end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_deassert: got %b want 0", irq); end
    apb(1'b1, 8'h00, 32'h1, rd, ok);
    m_write_ctrl(32'h1);
  endtask
`endif

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_abort();
    test_apb_abort();
    test_misc_regs();
    test_overflow();
    test_simultaneous();
`ifdef SPI_RX_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
